// File: rtl/emmc_cmd_responder_pkg.sv
// Shared eMMC token definitions: framing constants, token layout, responder
// states and the CRC7 helpers used by both the receive and transmit paths.
package jedec_p;

    localparam int         CMD_TOKEN_LEN = 48;
    localparam logic [6:0] CRC7_POLY     = 7'h09;
    localparam int         NCR_MIN       = 2;

    typedef struct packed {
        logic        start;
        logic        dir;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        stop;
    } cmd_token_t;

    typedef enum logic [1:0] {S_IDLE, S_RX, S_WAIT, S_TX} state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
        logic fb;
        fb = d ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] bits);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, bits[i]);
        return c;
    endfunction

endpackage

// File: rtl/emmc_cmd_responder_if.sv
// CMD line plus card-logic side signals of the responder, bundled for benches
// and card models that sit around emmc_cmd_responder.
interface emmc_cmd_responder_if;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        cmd_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_idx;
    logic [31:0] rsp_arg;
    logic        rsp_timeout;
    logic        busy;

    // master: host/card-logic side that drives the responder's inputs
    modport master (output cmd_in, rsp_valid, rsp_idx, rsp_arg,
                    input  cmd_out, cmd_oe, cmd_valid, cmd_idx, cmd_arg, cmd_err,
                           rsp_ready, rsp_timeout, busy);
    modport slave  (input  cmd_in, rsp_valid, rsp_idx, rsp_arg,
                    output cmd_out, cmd_oe, cmd_valid, cmd_idx, cmd_arg, cmd_err,
                           rsp_ready, rsp_timeout, busy);
endinterface

// File: rtl/emmc_cmd_responder_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0); clear takes priority over enable.
module emmc_crc7
    import jedec_p::*;
(
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       d_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i)     crc_d = '0;
        else if (en_i) crc_d = crc7_step(crc_q, d_i);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/emmc_cmd_responder.sv
// Card-side CMD line endpoint: receives 48-bit host commands, checks CRC7 and
// framing, then drives a 48-bit response after the NCR gap.
module emmc_cmd_responder
    import jedec_p::*;
#(
    parameter int NCR     = 2,
    parameter int NCR_MAX = 64
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_idx_o,
    output logic [31:0] cmd_arg_o,
    output logic        cmd_err_o,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic [5:0]  rsp_idx_i,
    input  logic [31:0] rsp_arg_i,
    output logic        rsp_timeout_o,
    output logic        busy_o
);
    localparam int CW = $clog2(NCR_MAX + 1);

    state_t        state_q, state_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [44:0]   rx_sh_q, rx_sh_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          lat_q, lat_d;
    logic [47:0]   tx_sh_q, tx_sh_d;
    logic          cmd_o_q, cmd_o_d, cmd_oe_q, cmd_oe_d;
    logic          cmd_valid_q, cmd_valid_d, cmd_err_q, cmd_err_d;
    logic [5:0]    cmd_idx_q, cmd_idx_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic          rsp_ready, hs, rx_bad;
    logic [6:0]    crc_rx;
    cmd_token_t    new_tok;
    logic [47:0]   new_bits, tok_start;

    // Only bits c1..c39 feed the checker; the start bit is 0 and leaves a zero CRC unchanged.
    emmc_crc7 u_rx_crc (
        .clk_i (clk_i),
        .srst_i(srst_i),
        .clr_i (state_q == S_IDLE),
        .en_i  (state_q == S_RX && bit_cnt_q <= 6'd39),
        .d_i   (cmd_i),
        .crc_o (crc_rx)
    );

    always_comb begin
        new_tok.start = 1'b0;
        new_tok.dir   = 1'b0;
        new_tok.idx   = rsp_idx_i;
        new_tok.arg   = rsp_arg_i;
        new_tok.crc   = crc7_40({2'b00, rsp_idx_i, rsp_arg_i});
        new_tok.stop  = 1'b1;
    end

    assign new_bits    = new_tok;
    assign tok_start   = lat_q ? tx_sh_q : new_bits;
    assign rsp_ready   = (state_q == S_WAIT) && !lat_q;
    assign hs          = rsp_valid_i && rsp_ready;
    // rx_sh_q holds bits c2..c46 when the end bit (c47) is on cmd_i
    assign rx_bad      = (rx_sh_q[6:0] != crc_rx) || !cmd_i;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sh_d       = rx_sh_q;
        wcnt_d        = wcnt_q;
        lat_d         = lat_q;
        tx_sh_d       = tx_sh_q;
        cmd_o_d       = cmd_o_q;
        cmd_oe_d      = cmd_oe_q;
        cmd_idx_d     = cmd_idx_q;
        cmd_arg_d     = cmd_arg_q;
        cmd_valid_d   = 1'b0;
        cmd_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cmd_i) begin
                    state_d   = S_RX;
                    bit_cnt_d = 6'd1;
                end
            end
            S_RX: begin
                rx_sh_d   = {rx_sh_q[43:0], cmd_i};
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd1 && !cmd_i) begin
                    state_d = S_IDLE;
                end else if (bit_cnt_q == 6'd47) begin
                    cmd_valid_d = 1'b1;
                    cmd_idx_d   = rx_sh_q[44:39];
                    cmd_arg_d   = rx_sh_q[38:7];
                    cmd_err_d   = rx_bad;
                    state_d     = rx_bad ? S_IDLE : S_WAIT;
                    wcnt_d      = CW'(1);
                    lat_d       = 1'b0;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + CW'(1);
                if (hs) begin
                    lat_d   = 1'b1;
                    tx_sh_d = new_bits;
                end
                // wcnt_q == j on the edge that is j cycles after the command end bit
                if ((hs || lat_q) && wcnt_q >= CW'(NCR - 1)) begin
                    state_d   = S_TX;
                    cmd_oe_d  = 1'b1;
                    cmd_o_d   = tok_start[47];
                    tx_sh_d   = {tok_start[46:0], 1'b0};
                    bit_cnt_d = 6'd1;
                end else if (wcnt_q == CW'(NCR_MAX - 1)) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_TX: begin
                if (bit_cnt_q == 6'd48) begin
                    cmd_oe_d = 1'b0;
                    cmd_o_d  = 1'b1;
                    lat_d    = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cmd_o_d   = tx_sh_q[47];
                    tx_sh_d   = {tx_sh_q[46:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            rx_sh_q       <= '0;
            wcnt_q        <= '0;
            lat_q         <= 1'b0;
            tx_sh_q       <= '0;
            cmd_o_q       <= 1'b1;
            cmd_oe_q      <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_idx_q     <= '0;
            cmd_arg_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sh_q       <= rx_sh_d;
            wcnt_q        <= wcnt_d;
            lat_q         <= lat_d;
            tx_sh_q       <= tx_sh_d;
            cmd_o_q       <= cmd_o_d;
            cmd_oe_q      <= cmd_oe_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_err_q     <= cmd_err_d;
            cmd_idx_q     <= cmd_idx_d;
            cmd_arg_q     <= cmd_arg_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_o         = cmd_o_q;
    assign cmd_oe_o      = cmd_oe_q;
    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_err_o     = cmd_err_q;
    assign cmd_idx_o     = cmd_idx_q;
    assign cmd_arg_o     = cmd_arg_q;
    assign rsp_ready_o   = rsp_ready;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = (state_q != S_IDLE);
endmodule
